// File: rtl/amplitude_mod_scheduler.sv
// Time-multiplexed amplitude scaler: one registered signed multiplier shared by all voices.
// Optional mix accumulator/saturation guarded by AMP_SCHED_MIX_EN.
module amplitude_mod_scheduler #(
  parameter int NUM_VOICES     = 4,
  parameter int DATA_BITS      = 12,
  parameter int AMPLITUDE_BITS = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 sample_tick,
  input  logic [NUM_VOICES*DATA_BITS-1:0]      din_bus,
  input  logic [NUM_VOICES*AMPLITUDE_BITS-1:0] amp_bus,
  input  logic [NUM_VOICES-1:0]                voice_enable,
  output logic [NUM_VOICES*DATA_BITS-1:0]      dout_bus,
  output logic [DATA_BITS-1:0]                 mix_out,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 overrun
);

  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int PW = DATA_BITS + AMPLITUDE_BITS + 1;
  localparam logic [DATA_BITS-1:0] MID =
    {1'b1, {(DATA_BITS-1){1'b0}}};
  localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] pidx_q;
  logic          pv_q;
  logic          load, issue;

  logic [NUM_VOICES*DATA_BITS-1:0]      din_q;
  logic [NUM_VOICES*AMPLITUDE_BITS-1:0] amp_q;
  logic [NUM_VOICES-1:0]                en_q;
  logic [NUM_VOICES*DATA_BITS-1:0]      dout_q;
  logic                                 done_q;
  logic                                 ovr_q;

  logic signed [PW-1:0]           prod_q;
  logic signed [DATA_BITS-1:0]    s_w;
  logic signed [AMPLITUDE_BITS:0] a_w;
  logic signed [PW-1:0]           p_w;
  logic signed [DATA_BITS-1:0]    y_w;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (sample_tick) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        issue = 1'b1;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Disabled voices multiply to zero so writeback needs no enable
  always_comb begin
    s_w = din_q[idx_q*DATA_BITS +: DATA_BITS] ^ MID;
    a_w = {1'b0, amp_q[idx_q*AMPLITUDE_BITS +: AMPLITUDE_BITS]};
    p_w = '0;
    if (en_q[idx_q]) p_w = s_w * a_w;
    y_w = DATA_BITS'(prod_q >>> AMPLITUDE_BITS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_q  <= '0;
      amp_q  <= '0;
      en_q   <= '0;
      prod_q <= '0;
      pidx_q <= '0;
      pv_q   <= 1'b0;
      dout_q <= {NUM_VOICES{MID}};
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      if (load) begin
        din_q <= din_bus;
        amp_q <= amp_bus;
        en_q  <= voice_enable;
      end
      pv_q <= issue;
      if (issue) begin
        prod_q <= p_w;
        pidx_q <= idx_q;
      end
      if (pv_q) dout_q[pidx_q*DATA_BITS +: DATA_BITS] <= y_w ^ MID;
      done_q <= (state_q == S_DONE);
      if (sample_tick && state_q != S_IDLE) ovr_q <= 1'b1;
    end
  end

`ifdef AMP_SCHED_MIX_EN
  localparam int AW = DATA_BITS + $clog2(NUM_VOICES);
  localparam logic signed [AW-1:0] SAT_HI = AW'((2 ** (DATA_BITS-1)) - 1);
  localparam logic signed [AW-1:0] SAT_LO = ~SAT_HI;

  logic signed [AW-1:0]  acc_q;
  logic [DATA_BITS-1:0]  mix_q;
  logic [DATA_BITS-1:0]  mix_c;

  always_comb begin
    mix_c = DATA_BITS'(acc_q) ^ MID;
    if (acc_q > SAT_HI)      mix_c = '1;
    else if (acc_q < SAT_LO) mix_c = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      mix_q <= MID;
    end else begin
      if (load)      acc_q <= '0;
      else if (pv_q) acc_q <= acc_q + AW'(y_w);
      if (state_q == S_DONE) mix_q <= mix_c;
    end
  end

  assign mix_out = mix_q;
`else
  assign mix_out = MID;
`endif

  assign dout_bus = dout_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_amplitude_mod_scheduler.sv
// Directed bench for amplitude_mod_scheduler (default parameters).
// Mix expectations follow AMP_SCHED_MIX_EN when it is defined.
module tb_amplitude_mod_scheduler;

  logic        clk;
  logic        rst_n;
  logic        sample_tick;
  logic [47:0] din_bus;
  logic [31:0] amp_bus;
  logic [3:0]  voice_enable;
  logic [47:0] dout_bus;
  logic [11:0] mix_out;
  logic        busy;
  logic        done;
  logic        overrun;

  int errors;
  int checks;

  amplitude_mod_scheduler #(
    .NUM_VOICES(4),
    .DATA_BITS(12),
    .AMPLITUDE_BITS(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sample_tick(sample_tick),
    .din_bus(din_bus),
    .amp_bus(amp_bus),
    .voice_enable(voice_enable),
    .dout_bus(dout_bus),
    .mix_out(mix_out),
    .busy(busy),
    .done(done),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] exp_mix(input logic [11:0] v);
`ifdef AMP_SCHED_MIX_EN
    return v;
`else
    return 12'h800;
`endif
  endfunction

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  // returns at the falling edge after E0
  task automatic kick(input logic [47:0] d, input logic [31:0] a,
                      input logic [3:0] e);
    @(negedge clk);
    din_bus      = d;
    amp_bus      = a;
    voice_enable = e;
    sample_tick  = 1'b1;
    @(negedge clk);
    sample_tick  = 1'b0;
  endtask

  task automatic test_reset;
    rst_n        = 1'b0;
    sample_tick  = 1'b0;
    din_bus      = '0;
    amp_bus      = '0;
    voice_enable = '0;
    #12;
    checks++;
    if (dout_bus !== {4{12'h800}}) begin
      errors++;
      $display("FAIL reset_dout: got %h exp %h", dout_bus, {4{12'h800}});
    end
    checks++;
    if (mix_out !== 12'h800) begin
      errors++;
      $display("FAIL reset_mix: got %h exp 800", mix_out);
    end
    checks++;
    if ({busy, done, overrun} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b exp 000", {busy, done, overrun});
    end
    @(negedge clk);
    rst_n = 1'b1;
    adv(2);
  endtask

  task automatic test_single_voice;
    kick({12'h000, 12'h000, 12'h000, 12'hFFF}, 32'h000000FF, 4'b0001);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy_e0: got %b exp 1", busy);
    end
    adv(1);
    checks++;
    if (dout_bus !== {4{12'h800}}) begin
      errors++;
      $display("FAIL single_dout_e1: got %h exp %h", dout_bus, {4{12'h800}});
    end
    adv(1);
    checks++;
    if (dout_bus !== {12'h800, 12'h800, 12'h800, 12'hFF7}) begin
      errors++;
      $display("FAIL single_dout_e2: got %h exp 800800800ff7", dout_bus);
    end
    adv(3);
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++;
      $display("FAIL single_e5: busy/done got %b exp 10", {busy, done});
    end
    adv(1);
    checks++;
    if ({busy, done} !== 2'b01) begin
      errors++;
      $display("FAIL single_e6: busy/done got %b exp 01", {busy, done});
    end
    checks++;
    if (mix_out !== exp_mix(12'hFF7)) begin
      errors++;
      $display("FAIL single_mix: got %h exp %h", mix_out, exp_mix(12'hFF7));
    end
    adv(1);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL single_done_e7: got %b exp 0", done);
    end
    adv(2);
  endtask

  // 0xC00*0x40=+256, 0x000*0x80=-1024, 0x7FF*0x01=-1 (floor), amp 0 -> 0
  task automatic test_scaling;
    kick({12'hABC, 12'h7FF, 12'h000, 12'hC00}, 32'h00_01_80_40, 4'b1111);
    adv(2);
    checks++;
    if (dout_bus !== {12'h800, 12'h800, 12'h800, 12'h900}) begin
      errors++;
      $display("FAIL scale_dout_e2: got %h exp 800800800900", dout_bus);
    end
    adv(1);
    checks++;
    if (dout_bus[23:12] !== 12'h400) begin
      errors++;
      $display("FAIL scale_v1_e3: got %h exp 400", dout_bus[23:12]);
    end
    adv(3);
    checks++;
    if (dout_bus !== {12'h800, 12'h7FF, 12'h400, 12'h900}) begin
      errors++;
      $display("FAIL scale_dout: got %h exp 8007ff400900", dout_bus);
    end
    checks++;
    if (mix_out !== exp_mix(12'h4FF)) begin
      errors++;
      $display("FAIL scale_mix: got %h exp %h", mix_out, exp_mix(12'h4FF));
    end
    adv(2);
  endtask

  task automatic test_saturation;
    kick({4{12'hFFF}}, {4{8'hFF}}, 4'b1111);
    adv(6);
    checks++;
    if (dout_bus !== {4{12'hFF7}}) begin
      errors++;
      $display("FAIL sat_hi_dout: got %h exp %h", dout_bus, {4{12'hFF7}});
    end
    checks++;
    if (done !== 1'b1 || mix_out !== exp_mix(12'hFFF)) begin
      errors++;
      $display("FAIL sat_hi_mix: done %b mix %h exp 1 %h",
               done, mix_out, exp_mix(12'hFFF));
    end
    adv(1);
    kick({4{12'h000}}, {4{8'hFF}}, 4'b1111);
    adv(6);
    checks++;
    if (dout_bus !== {4{12'h008}}) begin
      errors++;
      $display("FAIL sat_lo_dout: got %h exp %h", dout_bus, {4{12'h008}});
    end
    checks++;
    if (done !== 1'b1 || mix_out !== exp_mix(12'h000)) begin
      errors++;
      $display("FAIL sat_lo_mix: done %b mix %h exp 1 %h",
               done, mix_out, exp_mix(12'h000));
    end
    adv(2);
  endtask

  task automatic test_overrun;
    kick({12'h800, 12'h800, 12'hFFF, 12'hFFF}, 32'h00_00_80_80, 4'b0011);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_initial: got %b exp 0", overrun);
    end
    din_bus      = '0;
    amp_bus      = '1;
    voice_enable = '1;
    adv(2);
    sample_tick = 1'b1;
    adv(1);
    sample_tick = 1'b0;
    checks++;
    if ({busy, overrun} !== 2'b11) begin
      errors++;
      $display("FAIL ovr_run_tick: busy/ovr got %b exp 11", {busy, overrun});
    end
    adv(2);
    sample_tick = 1'b1;
    adv(1);
    sample_tick = 1'b0;
    checks++;
    if ({busy, done} !== 2'b01) begin
      errors++;
      $display("FAIL ovr_e6: busy/done got %b exp 01", {busy, done});
    end
    adv(1);
    checks++;
    if ({busy, done, overrun} !== 3'b001) begin
      errors++;
      $display("FAIL ovr_done_tick: flags got %b exp 001",
               {busy, done, overrun});
    end
    checks++;
    if (dout_bus !== {12'h800, 12'h800, 12'hBFF, 12'hBFF}) begin
      errors++;
      $display("FAIL ovr_dout: got %h exp 800800bffbff", dout_bus);
    end
    checks++;
    if (mix_out !== exp_mix(12'hFFE)) begin
      errors++;
      $display("FAIL ovr_mix: got %h exp %h", mix_out, exp_mix(12'hFFE));
    end
    adv(2);
  endtask

  task automatic test_reset_midframe;
    kick({4{12'hFFF}}, {4{8'hFF}}, 4'b1111);
    adv(3);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, overrun} !== 3'b000) begin
      errors++;
      $display("FAIL mid_rst_flags: got %b exp 000", {busy, done, overrun});
    end
    checks++;
    if (dout_bus !== {4{12'h800}} || mix_out !== 12'h800) begin
      errors++;
      $display("FAIL mid_rst_out: dout %h mix %h exp all 800",
               dout_bus, mix_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      adv(1);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_rst_idle%0d: busy/done got %b exp 00",
                 i, {busy, done});
      end
    end
    checks++;
    if (dout_bus !== {4{12'h800}}) begin
      errors++;
      $display("FAIL mid_rst_hold: got %h exp all 800", dout_bus);
    end
    kick({4{12'h000}}, {4{8'hFF}}, 4'b1111);
    adv(2);
    checks++;
    if (dout_bus !== {12'h800, 12'h800, 12'h800, 12'h008}) begin
      errors++;
      $display("FAIL mid_fresh_e2: got %h exp 800800800008", dout_bus);
    end
    adv(4);
    checks++;
    if (done !== 1'b1 || dout_bus !== {4{12'h008}}) begin
      errors++;
      $display("FAIL mid_fresh_e6: done %b dout %h exp 1 %h",
               done, dout_bus, {4{12'h008}});
    end
    checks++;
    if (mix_out !== exp_mix(12'h000)) begin
      errors++;
      $display("FAIL mid_fresh_mix: got %h exp %h", mix_out, exp_mix(12'h000));
    end
    adv(2);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single_voice();
    test_scaling();
    test_saturation();
    test_overrun();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/amplitude_mod_scheduler.md
# amplitude_mod_scheduler

Time-multiplexed amplitude-modulation scheduler: shares one registered signed multiplier among NUM_VOICES voices, applying each voice's envelope amplitude to its tone sample once per audio sample tick. It sits between the per-voice tone/ADSR generators and the output DAC path, producing per-voice scaled samples plus an optional saturated mix.

## Interface
Parameters:
- NUM_VOICES, 4: voices served per frame (≥1)
- DATA_BITS, 12: sample width, offset-binary (unsigned)
- AMPLITUDE_BITS, 8: amplitude width, unsigned

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- sample_tick  in  1  one-cycle frame start request
- din_bus  in  NUM_VOICES*DATA_BITS  voice k sample at [k*DATA_BITS +: DATA_BITS]
- amp_bus  in  NUM_VOICES*AMPLITUDE_BITS  voice k amplitude, same packing
- voice_enable  in  NUM_VOICES  bit k enables voice k
- dout_bus  out  NUM_VOICES*DATA_BITS  scaled voice samples, offset-binary
- mix_out  out  DATA_BITS  saturated sum of enabled voices, offset-binary
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse, frame complete
- overrun  out  1  sticky: tick arrived while not IDLE

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: sample_tick=1 → snapshot din_bus, amp_bus, voice_enable; idx=0; clear accumulator; busy=1; → RUN.
- RUN: issue voice idx to multiplier; idx++; after idx=NUM_VOICES-1 → FLUSH.
- FLUSH: write back last product → DONE.
- DONE: load mix_out, done=1, busy=0 → IDLE.
- Per-voice arithmetic: s = din ^ 2^(DATA_BITS-1) as signed; a = {0,amp} signed; p = s*a (DATA_BITS+AMPLITUDE_BITS+1 bits); y = p >>> AMPLITUDE_BITS (arithmetic, truncate toward −∞), fits DATA_BITS signed; dout = y ^ 2^(DATA_BITS-1).
- Disabled voice: y forced 0 (dout = midscale), contributes 0 to mix.
- Accumulator: signed, DATA_BITS+clog2(NUM_VOICES) bits; add y at each writeback; mix = clamp to [−2^(DATA_BITS-1), 2^(DATA_BITS-1)−1], then MSB toggled.
- Inputs changing mid-frame have no effect (snapshot).
- sample_tick while state≠IDLE (including DONE cycle): ignored, overrun←1; cleared only by reset.
- dout_bus voice k holds value until its next writeback.

## Timing
- E0 = edge sampling sample_tick in IDLE. Product for voice k registered at E(k+1); dout voice k and accumulator updated at E(k+2).
- Last writeback E(NUM_VOICES+1); mix_out, done=1, busy=0 at E(NUM_VOICES+2); done low at following edge.
- busy high from E0 to E(NUM_VOICES+2); frame length NUM_VOICES+2 cycles; next tick accepted at E(NUM_VOICES+3) earliest.
- Reset (any time, including mid-frame): state IDLE, idx 0, accumulator 0, dout_bus every voice 2^(DATA_BITS-1), mix_out 2^(DATA_BITS-1), busy 0, done 0, overrun 0; no partial writeback after release.

## Configuration
- AMP_SCHED_MIX_EN defined: accumulator, saturation and mix_out logic present as above.
- Undefined: no accumulator; mix_out constant 2^(DATA_BITS-1); dout_bus, busy, done, overrun timing unchanged.

## Test plan
- Defaults, voice0 din=0xFFF amp=0xFF, others disabled, tick → dout voice0=0xFF7 at E2, voices1-3 = 0x800, done at E6, mix_out=0xFF7.
- voice1 din=0x000 amp=0x80 → dout voice1=0x400; amp=0x00 any din → 0x800.
- All 4 voices din=0xFFF amp=0xFF → mix_out=0xFFF (saturated, raw sum 8156); all din=0x000 amp=0xFF → mix_out=0x000 (raw −8160).
- Tick at E0 and again at E3 and in DONE cycle → second/third ignored, overrun=1 and stays 1; frame results unchanged; change din_bus at E2 → no effect on frame.
- Assert rst_n low at E3 → immediately busy=0, done=0, all outputs midscale; no done pulse after release; fresh tick runs full frame normally.
- Without AMP_SCHED_MIX_EN: repeat saturation case → mix_out=0x800, dout values and done timing identical.
